axi_boundary_split_write: RTL and testbench

Parametrised AXI write-burst boundary splitter between Versat's memory-side write interfaces and the AXI master port. It captures each upstream burst command (address and length), checks whether the burst crosses a 2^BOUNDARY_W-byte boundary, and, if it does, reissues it downstream as two legal sub-bursts. It then streams the data beats through with per-part beat counting and a last-beat flag. Unlike a pure pass-through, it enforces the AXI 4 KB rule (or any power-of-two boundary) in hardware.

---
 rtl/axi_boundary_pkg.sv | 30 +++
 rtl/axi_boundary_split_write_calc.sv | 58 +++++
 rtl/axi_boundary_split_write.sv | 129 ++++++++++++
 tb/tb_axi_boundary_split_write.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_boundary_pkg.sv
// -----------------------------------------------------------------------------
// axi_boundary_pkg
// Shared definitions for the AXI write-burst boundary splitter.
//   - state_t      : splitter FSM states (IDLE=0, PART0=1, PART1=2)
//   - STRB_W       : byte-strobe width for the default 32-bit data path
//   - OFFSET_W     : address bits addressing a byte inside one beat (default)
//   - strb_width / offset_width : the same quantities for any DATA_W, used
//     by the parametrised modules so they follow their own DATA_W.
// -----------------------------------------------------------------------------
package axi_boundary_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PART0 = 2'd1,
      PART1 = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int STRB_W     = DEF_DATA_W / 8;
   localparam int OFFSET_W   = $clog2(STRB_W);

   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int offset_width(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi_boundary_split_write_calc.sv
// -----------------------------------------------------------------------------
// axi_boundary_calc
// Purely combinational split arithmetic for one burst command.
//   addr  in  ADDR_W  burst start byte address (unaligned bits are ignored)
//   len   in  LEN_W   burst beats - 1
//   split out 1       burst crosses a 2^BOUNDARY_W-byte boundary
//   len0  out LEN_W   beats - 1 of the first sub-burst
//   addr1 out ADDR_W  start address of the second sub-burst (next boundary)
//   len1  out LEN_W   beats - 1 of the second sub-burst (valid only if split)
// -----------------------------------------------------------------------------
module axi_boundary_calc
   import axi_boundary_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BOUNDARY_W = 12,
   parameter int LEN_W      = 8
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   output logic              split,
   output logic [LEN_W-1:0]  len0,
   output logic [ADDR_W-1:0] addr1,
   output logic [LEN_W-1:0]  len1
);

   localparam int SHIFT = offset_width(DATA_W);
   // Comparison width wide enough for both the beat total and the room count.
   localparam int CMP_W = (LEN_W > BOUNDARY_W) ? LEN_W + 1 : BOUNDARY_W + 1;

   localparam logic [ADDR_W-1:0] LOW_MASK   = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);
   localparam logic [ADDR_W-1:0] BOUND_SIZE = ADDR_W'(1) << BOUNDARY_W;
   localparam logic [ADDR_W-1:0] WIN_MASK   = BOUND_SIZE - ADDR_W'(1);

   logic [ADDR_W-1:0]   addr0;
   logic [BOUNDARY_W:0] offset;
   logic [BOUNDARY_W:0] avail;
   logic [CMP_W-1:0]    total_c;
   logic [CMP_W-1:0]    avail_c;

   assign addr0  = addr & ~LOW_MASK;
   assign offset = {1'b0, addr0[BOUNDARY_W-1:0]};

   // Beats that still fit before the next boundary; never zero because the
   // offset inside the window is strictly below the window size.
   assign avail   = ({1'b1, {BOUNDARY_W{1'b0}}} - offset) >> SHIFT;
   assign total_c = CMP_W'(len) + CMP_W'(1);
   assign avail_c = CMP_W'(avail);

   // A burst ending exactly on the boundary (total == avail) stays whole.
   assign split = (total_c > avail_c);
   assign len0  = split ? LEN_W'(avail_c - CMP_W'(1)) : len;
   assign len1  = LEN_W'(total_c - avail_c - CMP_W'(1));

   // Next boundary; the addition wraps modulo 2^ADDR_W at the top of memory.
   assign addr1 = (addr0 & ~WIN_MASK) + BOUND_SIZE;

endmodule

// File: rtl/axi_boundary_split_write.sv
// -----------------------------------------------------------------------------
// axi_boundary_split_write
// Captures an upstream write-burst command, splits it into at most two
// sub-bursts that never cross a 2^BOUNDARY_W-byte boundary, and streams the
// data beats through combinationally with a per-sub-burst last flag.
//   clk_i, rst_ni         clock / asynchronous active-low reset
//   s_valid_i, s_ready_o  upstream beat handshake
//   s_addr_i, s_len_i     burst command, sampled on the first beat only
//   s_wdata_i, s_wstrb_i  upstream beat payload
//   m_valid_o, m_ready_i  downstream beat handshake
//   m_addr_o, m_len_o     registered sub-burst command, stable per sub-burst
//   m_wdata_o, m_wstrb_o  downstream beat payload (pass-through)
//   m_last_o              last beat of the current sub-burst
// -----------------------------------------------------------------------------
module axi_boundary_split_write
   import axi_boundary_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BOUNDARY_W = 12,
   parameter int LEN_W      = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                s_valid_i,
   output logic                s_ready_o,
   input  logic [ADDR_W-1:0]   s_addr_i,
   input  logic [LEN_W-1:0]    s_len_i,
   input  logic [DATA_W-1:0]   s_wdata_i,
   input  logic [DATA_W/8-1:0] s_wstrb_i,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [ADDR_W-1:0]   m_addr_o,
   output logic [LEN_W-1:0]    m_len_o,
   output logic [DATA_W-1:0]   m_wdata_o,
   output logic [DATA_W/8-1:0] m_wstrb_o,
   output logic                m_last_o
);

   localparam int SHIFT = offset_width(DATA_W);
   localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

   state_t             state;
   logic [LEN_W-1:0]   count;
   logic [ADDR_W-1:0]  cur_addr;
   logic [LEN_W-1:0]   cur_len;
   logic [ADDR_W-1:0]  addr1_q;
   logic [LEN_W-1:0]   len1_q;
   logic               split_q;

   logic               calc_split;
   logic [LEN_W-1:0]   calc_len0;
   logic [ADDR_W-1:0]  calc_addr1;
   logic [LEN_W-1:0]   calc_len1;

   logic               active;
   logic               handshake;

   axi_boundary_calc #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .BOUNDARY_W (BOUNDARY_W),
      .LEN_W      (LEN_W)
   ) u_calc (
      .addr  (s_addr_i),
      .len   (s_len_i),
      .split (calc_split),
      .len0  (calc_len0),
      .addr1 (calc_addr1),
      .len1  (calc_len1)
   );

   // Beat path is a wire in both PART states; IDLE blocks it so the first
   // beat is never accepted in the capture cycle.
   assign active    = (state != IDLE);
   assign m_valid_o = active & s_valid_i;
   assign s_ready_o = active & m_ready_i;
   assign m_wdata_o = s_wdata_i;
   assign m_wstrb_o = s_wstrb_i;
   assign m_last_o  = active & (count == cur_len);
   assign m_addr_o  = cur_addr;
   assign m_len_o   = cur_len;
   assign handshake = m_valid_o & m_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         count    <= '0;
         cur_addr <= '0;
         cur_len  <= '0;
         addr1_q  <= '0;
         len1_q   <= '0;
         split_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid_i) begin
                  cur_addr <= s_addr_i & ~LOW_MASK;
                  cur_len  <= calc_len0;
                  addr1_q  <= calc_addr1;
                  len1_q   <= calc_len1;
                  split_q  <= calc_split;
                  count    <= '0;
                  state    <= PART0;
               end
            end
            PART0, PART1: begin
               if (handshake) begin
                  if (count == cur_len) begin
                     count <= '0;
                     // Second sub-burst follows without a bubble.
                     if (state == PART0 && split_q) begin
                        cur_addr <= addr1_q;
                        cur_len  <= len1_q;
                        state    <= PART1;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     count <= count + LEN_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_boundary_split_write.sv
module tb_axi_boundary_split_write;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BOUNDARY_W = 12;
   localparam int LEN_W      = 8;
   localparam int STRB_W     = DATA_W / 8;
   localparam longint BOUND  = 64'd1 << BOUNDARY_W;
   localparam longint BYTES  = DATA_W / 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                s_valid_i = 1'b0;
   logic                s_ready_o;
   logic [ADDR_W-1:0]   s_addr_i = '0;
   logic [LEN_W-1:0]    s_len_i = '0;
   logic [DATA_W-1:0]   s_wdata_i = '0;
   logic [STRB_W-1:0]   s_wstrb_i = '0;
   logic                m_valid_o;
   logic                m_ready_i = 1'b1;
   logic [ADDR_W-1:0]   m_addr_o;
   logic [LEN_W-1:0]    m_len_o;
   logic [DATA_W-1:0]   m_wdata_o;
   logic [STRB_W-1:0]   m_wstrb_o;
   logic                m_last_o;

   always #5 clk = ~clk;

   axi_boundary_split_write #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOUNDARY_W(BOUNDARY_W), .LEN_W(LEN_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .s_addr_i(s_addr_i), .s_len_i(s_len_i),
      .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .m_addr_o(m_addr_o), .m_len_o(m_len_o),
      .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
      .m_last_o(m_last_o)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic              last;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   logic  ready_toggle = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: how many beats fit between the aligned start and the next
   // boundary, and what is left over after it.
   function automatic void model_parts(input logic [ADDR_W-1:0] addr, input int len,
                                       output logic [ADDR_W-1:0] a0, output int l0,
                                       output logic [ADDR_W-1:0] a1, output int l1,
                                       output int nparts);
      longint base, room, total;
      base  = longint'(addr) - (longint'(addr) % BYTES);
      room  = (BOUND - (base % BOUND)) / BYTES;
      total = longint'(len) + 1;
      a0    = ADDR_W'(base);
      if (total <= room) begin
         nparts = 1; l0 = len; a1 = '0; l1 = 0;
      end else begin
         nparts = 2;
         l0 = int'(room) - 1;
         a1 = ADDR_W'(((base / BOUND) + 1) * BOUND);
         l1 = int'(total - room) - 1;
      end
   endfunction

   task automatic pin(input string name, input logic [ADDR_W-1:0] addr, input int len,
                      input int e_np, input logic [ADDR_W-1:0] e_a0, input int e_l0,
                      input logic [ADDR_W-1:0] e_a1, input int e_l1);
      logic [ADDR_W-1:0] a0, a1;
      int l0, l1, np;
      model_parts(addr, len, a0, l0, a1, l1, np);
      chk({name, "_part0"}, {4'(np), a0, LEN_W'(l0)}, {4'(e_np), e_a0, LEN_W'(e_l0)});
      chk({name, "_part1"}, {a1, LEN_W'(l1)}, {e_a1, LEN_W'(e_l1)});
   endtask

   // Downstream ready: always high, or toggling every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready_i = ready_toggle ? ~m_ready_i : 1'b1;
      end
   end

   // Compare process: every downstream beat must be the next modelled beat.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (!s_valid_i) chk("valid_without_upstream", m_valid_o, 1'b0);
         if (m_valid_o) chk("ready_passthrough", s_ready_o, m_ready_i);
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sub_burst_addr", m_addr_o, e.addr);
               chk("sub_burst_len", m_len_o, e.len);
               chk("beat_last", m_last_o, e.last);
               chk("beat_payload", {m_wstrb_o, m_wdata_o}, {e.strb, e.data});
            end
         end
      end
   end

   task automatic do_reset_pulse();
      rst_n = 1'b0;
      s_valid_i = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // abort_at >= 0: assert reset once that many beats have been accepted.
   task automatic send_burst(input logic [ADDR_W-1:0] addr, input int len,
                             input logic toggle, input int abort_at);
      logic [ADDR_W-1:0] a0, a1;
      int l0, l1, np, total, k, cycles, idx;
      logic hs;
      logic [DATA_W-1:0] d[$];
      logic [STRB_W-1:0] s[$];
      model_parts(addr, len, a0, l0, a1, l1, np);
      total = len + 1;
      for (int i = 0; i < total; i++) begin
         d.push_back(DATA_W'($urandom));
         s.push_back(STRB_W'($urandom));
      end
      idx = 0;
      for (int i = 0; i <= l0; i++) begin
         exp_q.push_back('{a0, LEN_W'(l0), (i == l0), d[idx], s[idx]});
         idx++;
      end
      if (np == 2) begin
         for (int i = 0; i <= l1; i++) begin
            exp_q.push_back('{a1, LEN_W'(l1), (i == l1), d[idx], s[idx]});
            idx++;
         end
      end
      ready_toggle = toggle;
      s_addr_i  = addr;
      s_len_i   = LEN_W'(len);
      s_valid_i = 1'b1;
      s_wdata_i = d[0];
      s_wstrb_i = s[0];
      k = 0;
      cycles = 0;
      while (k < total && cycles < 4 * total + 20) begin
         @(negedge clk);
         if (cycles == 0) chk("capture_bubble", {s_ready_o, m_valid_o}, 2'b00);
         hs = s_valid_i && s_ready_o;
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 1) begin
            // Command inputs must be ignored once captured.
            s_addr_i = ADDR_W'($urandom);
            s_len_i  = LEN_W'($urandom);
         end
         if (hs) begin
            k++;
            if (k == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk("reset_clears_outputs",
                   {s_ready_o, m_valid_o, m_last_o, m_addr_o, m_len_o}, 64'd0);
               s_valid_i = 1'b0;
               exp_q.delete();
               @(posedge clk);
               #1;
               rst_n = 1'b1;
               return;
            end
            if (k < total) begin
               s_wdata_i = d[k];
               s_wstrb_i = s[k];
            end else begin
               s_valid_i = 1'b0;
            end
         end
      end
      if (k < total) begin
         chk("burst_timeout", k, total);
         do_reset_pulse();
      end else if (!toggle) begin
         chk("burst_cycles", cycles, total + 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs",
          {s_ready_o, m_valid_o, m_last_o, m_addr_o, m_len_o}, 64'd0);
      rst_n = 1'b1;

      // Hand-computed expectations that pin the reference model.
      pin("model_1000_255", 32'h0000_1000, 255, 1, 32'h0000_1000, 255, 32'h0, 0);
      pin("model_0F00_255", 32'h0000_0F00, 255, 2, 32'h0000_0F00, 63, 32'h0000_1000, 191);
      pin("model_0FF8_3",   32'h0000_0FF8, 3,   2, 32'h0000_0FF8, 1,  32'h0000_1000, 1);
      pin("model_0FFC_0",   32'h0000_0FFC, 0,   1, 32'h0000_0FFC, 0,  32'h0, 0);
      pin("model_0FFE_1",   32'h0000_0FFE, 1,   2, 32'h0000_0FFC, 0,  32'h0000_1000, 0);
      pin("model_0F00_63",  32'h0000_0F00, 63,  1, 32'h0000_0F00, 63, 32'h0, 0);
      pin("model_wrap",     32'hFFFF_FF00, 255, 2, 32'hFFFF_FF00, 63, 32'h0000_0000, 191);

      send_burst(32'h0000_1000, 255, 1'b0, -1);
      send_burst(32'h0000_0F00, 255, 1'b0, -1);
      send_burst(32'h0000_0FF8, 3,   1'b1, -1);
      send_burst(32'h0000_0FFC, 0,   1'b0, -1);
      send_burst(32'h0000_0FFE, 1,   1'b0, -1);
      send_burst(32'h0000_0F00, 63,  1'b0, -1);
      send_burst(32'hFFFF_FF00, 255, 1'b0, -1);
      send_burst(32'h0000_0A10, 7,   1'b1, -1);
      // Reset while presenting the second beat of the second sub-burst.
      send_burst(32'h0000_0F00, 255, 1'b0, 65);
      send_burst(32'h0000_2000, 3,   1'b0, -1);
      send_burst(32'h0000_1FFC, 2,   1'b0, -1);

      repeat (3) @(posedge clk);
      #1;
      chk("all_beats_consumed", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
